id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RV64 pipeline, paired with load-use hazard detection.
- Captures decoded operands and the seven control signals from the decode-stage control unit every cycle.
- Drives the control unit's `stall` input, the PC write enable and the IF/ID write enable.
- Inserts bubbles on load-use stalls and on taken-branch flushes.
- Keeps saturating bubble/flush event counters for performance debug.

Parameters:
- XLEN, 64, datapath width of PC, operands and immediate
- CNT_W, 32, width of each event counter

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- flush  input  1  taken branch resolved downstream; squash the ID-stage instruction
- id_pc  input  XLEN  PC of the ID-stage instruction
- id_rs1_data  input  XLEN  register-file read port 1
- id_rs2_data  input  XLEN  register-file read port 2
- id_imm  input  XLEN  sign-extended immediate
- id_rs1  input  5  source register 1 index
- id_rs2  input  5  source register 2 index
- id_rd  input  5  destination register index
- id_funct4  input  4  {inst[30], inst[14:12]} for ALU control
- id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write  input  1 each  decode-stage control
- id_alu_op  input  2  decode-stage ALUOp
- stall  output  1  to control unit; zeroes its outputs
- pc_write  output  1  PC register enable
- if_id_write  output  1  IF/ID register enable
- ex_valid  output  1  EX stage holds a real instruction
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  output  XLEN  registered operands
- ex_rs1, ex_rs2, ex_rd  output  5  registered indices (used by forwarding)
- ex_funct4  output  4  registered funct fields
- ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write  output  1 each  registered control
- ex_alu_op  output  2  registered ALUOp
- bubble_count  output  CNT_W  number of load-use bubbles inserted
- flush_count  output  CNT_W  number of flush bubbles inserted

Behaviour:
- Reset (reset_n low, asynchronous): every ex_* output and both counters are 0; ex_valid is 0.
  - Outputs during reset: stall=0, pc_write=1, if_id_write=1.
  - Reset mid-stall drops the stall immediately, with no clock edge needed.
- Hazard detect, combinational from registered EX state and current ID indices:
  - hazard = ex_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
  - stall = hazard & ~flush.
  - pc_write = ~stall; if_id_write = ~stall.
- Register update, each rising clk edge, in priority order:
  - flush=1: load a bubble. All ex_* control bits 0, ex_alu_op=0, ex_valid=0, data/index fields 0. flush_count += 1, saturating at all-ones. Flush takes priority over hazard; bubble_count is not incremented.
  - else stall=1: load a bubble as above. bubble_count += 1, saturating.
  - else: load every id_* input into its ex_* counterpart; ex_valid=1.
- Latency: one cycle ID to EX.
- A load-use stall lasts exactly one cycle. The bubble clears ex_mem_read, so hazard deasserts on the next cycle and the stalled instruction advances.
- Hazard checks use both rs1 and rs2 regardless of instruction format. A false stall (e.g. rs2 field of an I-type) is accepted.
- rd = x0 never causes a stall.
- Consecutive load to dependent load: stall once, then proceed. A chain of dependent loads stalls once per pair.
- Back-to-back flushes each insert a bubble and each increment flush_count.
- The counters wrap never: they hold at 2^CNT_W − 1.

Decomposition:
- Shared package `pipe_pkg`:
  - XLEN and REG_IDX_W=5 constants.
  - ALUOp encodings: ALUOP_ADD=2'b00, ALUOP_BR=2'b01, ALUOP_RTYPE=2'b10.
  - Packed struct ctrl_t {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op}, with a CTRL_BUBBLE all-zero constant.
- One sub-module is natural: `hazard_detect`, the combinational load-use compare that produces stall, pc_write and if_id_write.
- The register and counters stay in the top module.

Test Plan:
- Reset: assert reset_n=0 mid-cycle while a stall is active → all ex_* outputs 0, counters 0, stall=0 and pc_write=1 immediately, with no clock edge.
- Normal flow: present an R-type (rd=5, rs1=1, rs2=2, ALUOp=10, RegWrite=1, id_imm=0x10) → next edge ex_reg_write=1, ex_alu_op=2'b10, ex_imm=0x10, ex_valid=1, stall=0.
- Load-use: ld x5 in EX, then ID add x6,x5,x7 → stall=1, pc_write=0, if_id_write=0. Next edge: ex_valid=0, bubble_count=1. Following cycle: stall=0, and the add is captured on the next edge.
- x0 and no-match: ld x0 in EX with ID rs1=0 → stall=0. ld x5 in EX with ID rs1=6, rs2=7 → stall=0.
- Flush vs stall: load-use hazard present and flush=1 in the same cycle → stall=0, bubble loaded, flush_count=1, bubble_count unchanged.
- Saturation: with CNT_W=4, force 17 consecutive flushes → flush_count holds at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the RV64 5-stage pipeline: widths, ALUOp codes and
// the bundle of decode-stage control bits carried down the pipe.
package pipe_pkg;

  localparam int XLEN      = 64;
  localparam int REG_IDX_W = 5;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: stalls PC and IF/ID for one cycle when the load
// in EX writes a register the ID-stage instruction reads.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic                 ex_valid,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 flush,
  output logic                 stall,
  output logic                 pc_write,
  output logic                 if_id_write
);

  logic hazard;

  // Both source fields are compared whatever the format; a spurious stall is harmless.
  assign hazard = ex_valid & ex_mem_read & (ex_rd != '0) &
                  ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  // A flush squashes the dependent instruction anyway, so stalling would only lose a cycle.
  assign stall       = hazard & ~flush;
  assign pc_write    = ~stall;
  assign if_id_write = ~stall;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and branch-flush bubble
// insertion, plus saturating bubble/flush event counters.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN  = pipe_pkg::XLEN,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [XLEN-1:0]      id_rs1_data,
  input  logic [XLEN-1:0]      id_rs2_data,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic [3:0]           id_funct4,
  input  logic                 id_branch,
  input  logic                 id_mem_read,
  input  logic                 id_mem_to_reg,
  input  logic                 id_mem_write,
  input  logic                 id_alu_src,
  input  logic                 id_reg_write,
  input  logic [1:0]           id_alu_op,
  output logic                 stall,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 ex_valid,
  output logic [XLEN-1:0]      ex_pc,
  output logic [XLEN-1:0]      ex_rs1_data,
  output logic [XLEN-1:0]      ex_rs2_data,
  output logic [XLEN-1:0]      ex_imm,
  output logic [REG_IDX_W-1:0] ex_rs1,
  output logic [REG_IDX_W-1:0] ex_rs2,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic [3:0]           ex_funct4,
  output logic                 ex_branch,
  output logic                 ex_mem_read,
  output logic                 ex_mem_to_reg,
  output logic                 ex_mem_write,
  output logic                 ex_alu_src,
  output logic                 ex_reg_write,
  output logic [1:0]           ex_alu_op,
  output logic [CNT_W-1:0]     bubble_count,
  output logic [CNT_W-1:0]     flush_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ctrl_t                id_ctrl;
  ctrl_t                ctrl_p1;
  logic                 vld_p1;
  logic [XLEN-1:0]      pc_p1, rs1_data_p1, rs2_data_p1, imm_p1;
  logic [REG_IDX_W-1:0] rs1_p1, rs2_p1, rd_p1;
  logic [3:0]           funct4_p1;

  assign id_ctrl = {id_branch, id_mem_read, id_mem_to_reg, id_mem_write,
                    id_alu_src, id_reg_write, id_alu_op};

  hazard_detect u_hazard (
    .ex_valid    (vld_p1),
    .ex_mem_read (ctrl_p1.mem_read),
    .ex_rd       (rd_p1),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .flush       (flush),
    .stall       (stall),
    .pc_write    (pc_write),
    .if_id_write (if_id_write)
  );

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1       <= 1'b0;
      ctrl_p1      <= CTRL_BUBBLE;
      pc_p1        <= '0;
      rs1_data_p1  <= '0;
      rs2_data_p1  <= '0;
      imm_p1       <= '0;
      rs1_p1       <= '0;
      rs2_p1       <= '0;
      rd_p1        <= '0;
      funct4_p1    <= '0;
      bubble_count <= '0;
      flush_count  <= '0;
    end else if (flush || stall) begin
      vld_p1       <= 1'b0;
      ctrl_p1      <= CTRL_BUBBLE;
      pc_p1        <= '0;
      rs1_data_p1  <= '0;
      rs2_data_p1  <= '0;
      imm_p1       <= '0;
      rs1_p1       <= '0;
      rs2_p1       <= '0;
      rd_p1        <= '0;
      funct4_p1    <= '0;
      // stall is already gated by flush, so exactly one counter moves.
      if (flush) flush_count  <= sat_inc(flush_count);
      else       bubble_count <= sat_inc(bubble_count);
    end else begin
      vld_p1       <= 1'b1;
      ctrl_p1      <= id_ctrl;
      pc_p1        <= id_pc;
      rs1_data_p1  <= id_rs1_data;
      rs2_data_p1  <= id_rs2_data;
      imm_p1       <= id_imm;
      rs1_p1       <= id_rs1;
      rs2_p1       <= id_rs2;
      rd_p1        <= id_rd;
      funct4_p1    <= id_funct4;
    end
  end

  assign ex_valid      = vld_p1;
  assign ex_pc         = pc_p1;
  assign ex_rs1_data   = rs1_data_p1;
  assign ex_rs2_data   = rs2_data_p1;
  assign ex_imm        = imm_p1;
  assign ex_rs1        = rs1_p1;
  assign ex_rs2        = rs2_p1;
  assign ex_rd         = rd_p1;
  assign ex_funct4     = funct4_p1;
  assign ex_branch     = ctrl_p1.branch;
  assign ex_mem_read   = ctrl_p1.mem_read;
  assign ex_mem_to_reg = ctrl_p1.mem_to_reg;
  assign ex_mem_write  = ctrl_p1.mem_write;
  assign ex_alu_src    = ctrl_p1.alu_src;
  assign ex_reg_write  = ctrl_p1.reg_write;
  assign ex_alu_op     = ctrl_p1.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed load-use/flush/reset scenarios plus random
// traffic, all checked against a behavioural pipeline model every cycle.
module tb_id_ex_stage;
  import pipe_pkg::*;

  localparam int XL  = 64;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk, reset_n, flush;
  logic [XL-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [3:0] id_funct4;
  logic id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write;
  logic [1:0] id_alu_op;
  logic stall, pc_write, if_id_write, ex_valid;
  logic [XL-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [3:0] ex_funct4;
  logic ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write;
  logic [1:0] ex_alu_op;
  logic [CW-1:0] bubble_count, flush_count;

  int tests = 0;
  int fails = 0;

  id_ex_stage #(.XLEN(XL), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct4(id_funct4),
    .id_branch(id_branch), .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg),
    .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_alu_op(id_alu_op),
    .stall(stall), .pc_write(pc_write), .if_id_write(if_id_write), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct4(ex_funct4),
    .ex_branch(ex_branch), .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
    .ex_alu_op(ex_alu_op), .bubble_count(bubble_count), .flush_count(flush_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: what instruction (if any) sits in EX, and event tallies.
  typedef struct {
    bit        valid;
    bit [XL-1:0] pc, d1, d2, imm;
    bit [4:0]  rs1, rs2, rd;
    bit [3:0]  f4;
    bit [7:0]  ctrl;
  } slot_t;

  slot_t m;
  int m_bubbles, m_flushes;

  function automatic bit model_stall();
    bit reads_rd;
    reads_rd = (m.rd == id_rs1) || (m.rd == id_rs2);
    return m.valid && m.ctrl[6] && (m.rd != 0) && reads_rd && !flush;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m = '{default: '0};
      m_bubbles = 0;
      m_flushes = 0;
    end else if (flush) begin
      m = '{default: '0};
      if (m_flushes < CMAX) m_flushes++;
    end else if (model_stall()) begin
      m = '{default: '0};
      if (m_bubbles < CMAX) m_bubbles++;
    end else begin
      m.valid = 1;
      m.pc = id_pc; m.d1 = id_rs1_data; m.d2 = id_rs2_data; m.imm = id_imm;
      m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd; m.f4 = id_funct4;
      m.ctrl = {id_branch, id_mem_read, id_mem_to_reg, id_mem_write,
                id_alu_src, id_reg_write, id_alu_op};
    end
  end

  always @(negedge clk) begin
    logic [299:0] act, exp;
    bit s;
    s = model_stall();
    act = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_funct4, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src,
           ex_reg_write, ex_alu_op, bubble_count, flush_count, stall, pc_write, if_id_write};
    exp = {m.valid, m.pc, m.d1, m.d2, m.imm, m.rs1, m.rs2, m.rd, m.f4, m.ctrl,
           CW'(m_bubbles), CW'(m_flushes), s, !s, !s};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL cycle_compare t=%0t got=%h expected=%h", $time, act, exp);
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input ctrl_t c, input logic [XL-1:0] imm, input logic fl);
    id_pc       = {$urandom, $urandom};
    id_rs1_data = {$urandom, $urandom};
    id_rs2_data = {$urandom, $urandom};
    id_imm      = imm;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_funct4 = 4'($urandom);
    {id_branch, id_mem_read, id_mem_to_reg, id_mem_write,
     id_alu_src, id_reg_write, id_alu_op} = c;
    flush = fl;
  endtask

  ctrl_t c_rtype, c_ld, c_rand;

  initial begin
    c_rtype = '{branch:0, mem_read:0, mem_to_reg:0, mem_write:0, alu_src:0, reg_write:1, alu_op:ALUOP_RTYPE};
    c_ld    = '{branch:0, mem_read:1, mem_to_reg:1, mem_write:0, alu_src:1, reg_write:1, alu_op:ALUOP_ADD};
    reset_n = 1'b0;
    drive(5'd0, 5'd0, 5'd0, CTRL_BUBBLE, '0, 1'b0);
    #2;
    check("reset_valid", ex_valid, 0);
    check("reset_pc_write", pc_write, 1);
    check("reset_counts", {bubble_count, flush_count}, 0);
    step(); step();
    reset_n = 1'b1;

    // Normal R-type flow
    drive(5'd1, 5'd2, 5'd5, c_rtype, 64'h10, 1'b0);
    step();
    check("rtype_reg_write", ex_reg_write, 1);
    check("rtype_alu_op", ex_alu_op, 2'b10);
    check("rtype_imm", ex_imm, 64'h10);
    check("rtype_valid", ex_valid, 1);
    check("rtype_stall", stall, 0);

    // Load-use: ld x5 then add x6,x5,x7
    drive(5'd1, 5'd0, 5'd5, c_ld, 64'h8, 1'b0);
    step();
    drive(5'd5, 5'd7, 5'd6, c_rtype, 64'h0, 1'b0);
    #1;
    check("lu_stall", stall, 1);
    check("lu_pc_write", pc_write, 0);
    check("lu_if_id_write", if_id_write, 0);
    step();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_count", bubble_count, 1);
    check("lu_stall_clears", stall, 0);
    step();
    check("lu_add_rd", ex_rd, 6);
    check("lu_add_valid", ex_valid, 1);

    // rd = x0 and no-match loads
    drive(5'd1, 5'd0, 5'd0, c_ld, 64'h0, 1'b0);
    step();
    drive(5'd0, 5'd0, 5'd3, c_rtype, 64'h0, 1'b0);
    #1;
    check("x0_no_stall", stall, 0);
    drive(5'd1, 5'd0, 5'd5, c_ld, 64'h0, 1'b0);
    step();
    drive(5'd6, 5'd7, 5'd3, c_rtype, 64'h0, 1'b0);
    #1;
    check("nomatch_no_stall", stall, 0);

    // Flush beats stall
    drive(5'd1, 5'd0, 5'd5, c_ld, 64'h0, 1'b0);
    step();
    drive(5'd5, 5'd0, 5'd3, c_rtype, 64'h0, 1'b1);
    #1;
    check("flush_gates_stall", stall, 0);
    step();
    check("flush_bubble_valid", ex_valid, 0);
    check("flush_count_1", flush_count, 1);
    check("flush_bubble_count_held", bubble_count, 1);

    // Random traffic with a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      c_rand = ctrl_t'($urandom);
      drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            c_rand, {$urandom, $urandom}, ($urandom_range(0, 9) == 0));
      step();
    end

    // Saturation: 17 back-to-back flushes
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(5'd1, 5'd2, 5'd3, c_ld, 64'h0, 1'b1);
      step();
    end
    check("flush_saturate", flush_count, 15);

    // Reset in the middle of an active stall
    drive(5'd1, 5'd0, 5'd5, c_ld, 64'h0, 1'b0);
    step();
    drive(5'd5, 5'd0, 5'd3, c_rtype, 64'h0, 1'b0);
    #1;
    check("pre_reset_stall", stall, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset_stall", stall, 0);
    check("async_reset_pc_write", pc_write, 1);
    check("async_reset_ex", {ex_valid, ex_rd, ex_mem_read, ex_pc[31:0]}, 0);
    check("async_reset_counts", {bubble_count, flush_count}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
